// File: rtl/arc4_ctrl_if.sv
// ARC4 sequencer bus bundle: task-top handshake, sub-block en/rdy + S write buses, S memory port.
// Latency: none (wires only).
// Backpressure: carried by the en/rdy pairs; master = sequencer side, slave = environment side.
interface arc4_ctrl_if;
  logic       en;
  logic       rdy;
  logic       done;
  logic [1:0] phase;
  logic       err;

  logic       init_en;
  logic       ksa_en;
  logic       prga_en;
  logic       init_rdy;
  logic       ksa_rdy;
  logic       prga_rdy;

  logic [7:0] init_addr;
  logic [7:0] ksa_addr;
  logic [7:0] prga_addr;
  logic [7:0] init_wrdata;
  logic [7:0] ksa_wrdata;
  logic [7:0] prga_wrdata;
  logic       init_wren;
  logic       ksa_wren;
  logic       prga_wren;

  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;

  modport master (
    input  en,
    output rdy, done, phase, err,
    output init_en, ksa_en, prga_en,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output s_addr, s_wrdata, s_wren
  );

  modport slave (
    output en,
    input  rdy, done, phase, err,
    input  init_en, ksa_en, prga_en,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_ctrl.sv
// ARC4 sequencer: runs init -> ksa -> (prga) via en/rdy and muxes the owning sub-block onto S memory.
// Latency: 1 START cycle + handshake per phase, +1 FIN cycle; S bus mux is zero-latency from owner.
// Backpressure: en taken only when rdy=1 (IDLE); waits on each sub-block rdy. Watchdog: ARC4_WDOG_EN.
module arc4_ctrl #(
  parameter int RUN_PRGA    = 1,
  parameter int WDOG_CYCLES = 1024
) (
  input logic        clk,
  input logic        rst_n,
  arc4_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_START,
    S_INIT_WAIT,
    S_KSA_START,
    S_KSA_WAIT,
    S_PRGA_START,
    S_PRGA_WAIT,
    S_FIN,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } owner_t;

  // Watchdog limit must fit the 16-bit wait counter.
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_wdog_range
    $error("arc4_ctrl: WDOG_CYCLES out of range");
  end

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  logic   seen_busy, seen_busy_nxt;
  logic   init_en, ksa_en, prga_en;
  logic   in_wait;

  assign in_wait = (state == S_INIT_WAIT) || (state == S_KSA_WAIT) || (state == S_PRGA_WAIT);

`ifdef ARC4_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_cnt;
  logic        wait_entry;

  assign wait_entry = !in_wait &&
                      ((state_nxt == S_INIT_WAIT) || (state_nxt == S_KSA_WAIT) ||
                       (state_nxt == S_PRGA_WAIT));

  // Wait-cycle counter: zeroed on entry to each WAIT, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wdog_cnt <= '0;
    else if (wait_entry) wdog_cnt <= '0;
    else if (in_wait)    wdog_cnt <= wdog_cnt + 16'd1;
  end
`endif

  // State, owner and stale-rdy guard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= OWN_NONE;
      seen_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      seen_busy <= seen_busy_nxt;
    end
  end

  // Next-state and start pulses; a WAIT only ends once the sub-block has been seen busy.
  always_comb begin
    state_nxt     = state;
    seen_busy_nxt = seen_busy;
    init_en       = 1'b0;
    ksa_en        = 1'b0;
    prga_en       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.en) state_nxt = S_INIT_START;
      end
      S_INIT_START: begin
        if (bus.init_rdy) begin
          init_en       = 1'b1;
          state_nxt     = S_INIT_WAIT;
          seen_busy_nxt = 1'b0;
        end
      end
      S_INIT_WAIT: begin
        if (!bus.init_rdy)  seen_busy_nxt = 1'b1;
        else if (seen_busy) state_nxt     = S_KSA_START;
      end
      S_KSA_START: begin
        if (bus.ksa_rdy) begin
          ksa_en        = 1'b1;
          state_nxt     = S_KSA_WAIT;
          seen_busy_nxt = 1'b0;
        end
      end
      S_KSA_WAIT: begin
        if (!bus.ksa_rdy)   seen_busy_nxt = 1'b1;
        else if (seen_busy) state_nxt     = (RUN_PRGA != 0) ? S_PRGA_START : S_FIN;
      end
      S_PRGA_START: begin
        if (bus.prga_rdy) begin
          prga_en       = 1'b1;
          state_nxt     = S_PRGA_WAIT;
          seen_busy_nxt = 1'b0;
        end
      end
      S_PRGA_WAIT: begin
        if (!bus.prga_rdy)  seen_busy_nxt = 1'b1;
        else if (seen_busy) state_nxt     = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
`ifdef ARC4_WDOG_EN
    // A normal phase exit wins over a watchdog expiry in the same cycle.
    if (in_wait && (state_nxt == state) && (wdog_cnt == WDOG_LIM)) state_nxt = S_ERR;
`endif
  end

  // Owner is registered from the next state so it is valid throughout START and WAIT.
  always_comb begin
    owner_nxt = OWN_NONE;
    case (state_nxt)
      S_INIT_START, S_INIT_WAIT: owner_nxt = OWN_INIT;
      S_KSA_START,  S_KSA_WAIT:  owner_nxt = OWN_KSA;
      S_PRGA_START, S_PRGA_WAIT: owner_nxt = OWN_PRGA;
      default:                   owner_nxt = OWN_NONE;
    endcase
  end

  // S memory bus: only the owner reaches memory; no owner means a quiet bus.
  always_comb begin
    bus.s_addr   = 8'h00;
    bus.s_wrdata = 8'h00;
    bus.s_wren   = 1'b0;
    case (owner)
      OWN_INIT: begin
        bus.s_addr   = bus.init_addr;
        bus.s_wrdata = bus.init_wrdata;
        bus.s_wren   = bus.init_wren;
      end
      OWN_KSA: begin
        bus.s_addr   = bus.ksa_addr;
        bus.s_wrdata = bus.ksa_wrdata;
        bus.s_wren   = bus.ksa_wren;
      end
      OWN_PRGA: begin
        bus.s_addr   = bus.prga_addr;
        bus.s_wrdata = bus.prga_wrdata;
        bus.s_wren   = bus.prga_wren;
      end
      default: begin
        bus.s_addr   = 8'h00;
        bus.s_wrdata = 8'h00;
        bus.s_wren   = 1'b0;
      end
    endcase
  end

  assign bus.init_en = init_en;
  assign bus.ksa_en  = ksa_en;
  assign bus.prga_en = prga_en;
  assign bus.rdy     = (state == S_IDLE);
  assign bus.done    = (state == S_FIN);
  assign bus.phase   = owner;
`ifdef ARC4_WDOG_EN
  assign bus.err     = (state == S_ERR);
`else
  assign bus.err     = 1'b0;
`endif

endmodule
